// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Holds the FSM state encoding, the requester identities and the store-length codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arbState_e;

  typedef enum logic [1:0] {
    OWN_LD = 2'd0,
    OWN_IF = 2'd1,
    OWN_D  = 2'd2
  } owner_e;

  localparam logic [2:0] LEN_B   = 3'b001;
  localparam logic [2:0] LEN_H   = 3'b010;
  localparam logic [2:0] LEN_W   = 3'b100;
  localparam logic [3:0] BE_FULL = 4'b1111;

  function automatic logic [31:0] replicateByte(input logic [7:0] b);
    return {b, b, b, b};
  endfunction

  function automatic logic [31:0] replicateHalf(input logic [15:0] h);
    return {h, h};
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the arbiter: one access strobe plus command and read data.
// The arbiter drives it through the master modport; the memory macro uses the slave modport.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_be,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_be,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter_lane_align.sv
// Combinational store lane steering: byte enables, replicated write data and
// the misalignment flag from the low address bits and the store length code.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [2:0]  len,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] alignedWdata,
  output logic        misalign
);

  // Decode lanes per length; unknown length codes fall back to a full word
  always_comb begin
    be           = BE_FULL;
    alignedWdata = wdata;
    misalign     = 1'b0;
    case (len)
      LEN_B: begin
        be           = 4'b0001 << addrLo;
        alignedWdata = replicateByte(wdata[7:0]);
        misalign     = 1'b0;
      end
      LEN_H: begin
        if (addrLo[1]) begin
          be = 4'b1100;
        end else begin
          be = 4'b0011;
        end
        alignedWdata = replicateHalf(wdata[15:0]);
        misalign     = addrLo[0];
      end
      default: begin
        be           = BE_FULL;
        alignedWdata = wdata;
        misalign     = (addrLo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch, data load/store and the
// program loader, sequencing each access at a fixed latency and stalling the CPU meanwhile.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_ready,
  input  logic [2:0]            d_rd,
  input  logic [1:0]            d_wr,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [2:0]            d_len,
  output logic [31:0]           d_rdata,
  output logic                  d_ready,
  input  logic                  ld_req,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [31:0]           ld_wdata,
  output logic                  ld_ready,
  unified_mem_arbiter_if.master memBus,
  output logic                  cpu_stall,
  output logic                  err_misalign
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY);

  arbState_e         state_r, nextState_s;
  owner_e            owner_r, lastCpu_r, grantOwner_s;
  logic [2:0]        cnt_r;
  logic [ADDR_W-1:0] cmdAddr_r, cmdAddrNext_s;
  logic              cmdWe_r, cmdWeNext_s;
  logic [3:0]        cmdBe_r, cmdBeNext_s;
  logic [31:0]       cmdWdata_r, cmdWdataNext_s;
  logic [31:0]       ifRdata_r, dRdata_r;
  logic              misalign_r;

  logic              ldPend_s, ifPend_s, dPend_s, dStore_s;
  logic              grantValid_s, badStore_s;
  logic [3:0]        alignBe_s;
  logic [31:0]       alignWdata_s;
  logic              alignMis_s;
  logic              unusedAddrBits_s;

  assign unusedAddrBits_s = ^{if_addr[1:0], ld_addr[1:0]};

  assign ldPend_s = ld_req;
  assign ifPend_s = if_req;
  assign dStore_s = (d_wr != 2'b00);
  assign dPend_s  = dStore_s | (d_rd != 3'b000);

  mem_lane_align u_laneAlign (
    .addrLo       (d_addr[1:0]),
    .len          (d_len),
    .wdata        (d_wdata),
    .be           (alignBe_s),
    .alignedWdata (alignWdata_s),
    .misalign     (alignMis_s)
  );

  // Fixed-priority loader, then round-robin between fetch and data on a tie
  always_comb begin
    grantValid_s = ldPend_s | ifPend_s | dPend_s;
    grantOwner_s = OWN_IF;
    if (ldPend_s) begin
      grantOwner_s = OWN_LD;
    end else if (ifPend_s && dPend_s) begin
      grantOwner_s = (lastCpu_r == OWN_IF) ? OWN_D : OWN_IF;
    end else if (dPend_s) begin
      grantOwner_s = OWN_D;
    end else begin
      grantOwner_s = OWN_IF;
    end
    badStore_s = (grantOwner_s == OWN_D) && dStore_s && alignMis_s;
  end

  // Build the word-aligned command the winner will present to memory
  always_comb begin
    cmdAddrNext_s  = {if_addr[ADDR_W-1:2], 2'b00};
    cmdWeNext_s    = 1'b0;
    cmdBeNext_s    = BE_FULL;
    cmdWdataNext_s = 32'h0000_0000;
    case (grantOwner_s)
      OWN_LD: begin
        cmdAddrNext_s  = {ld_addr[ADDR_W-1:2], 2'b00};
        cmdWeNext_s    = 1'b1;
        cmdWdataNext_s = ld_wdata;
      end
      OWN_D: begin
        cmdAddrNext_s = {d_addr[ADDR_W-1:2], 2'b00};
        if (dStore_s) begin
          cmdWeNext_s    = 1'b1;
          cmdBeNext_s    = alignBe_s;
          cmdWdataNext_s = alignWdata_s;
        end else begin
          cmdWeNext_s    = 1'b0;
          cmdBeNext_s    = BE_FULL;
        end
      end
      default: begin
        cmdAddrNext_s = {if_addr[ADDR_W-1:2], 2'b00};
      end
    endcase
  end

  // Next-state logic; a misaligned store skips the memory entirely
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!grantValid_s) begin
          nextState_s = ST_IDLE;
        end else if (badStore_s) begin
          nextState_s = ST_DONE;
        end else begin
          nextState_s = ST_ISSUE;
        end
      end
      ST_ISSUE: nextState_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r <= 3'd1) begin
          nextState_s = ST_DONE;
        end else begin
          nextState_s = ST_WAIT;
        end
      end
      ST_DONE: nextState_s = ST_IDLE;
      default: nextState_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Grant capture, latency count, read-data capture and round-robin history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_r    <= OWN_LD;
      lastCpu_r  <= OWN_D;
      cnt_r      <= 3'd0;
      cmdAddr_r  <= '0;
      cmdWe_r    <= 1'b0;
      cmdBe_r    <= 4'b0000;
      cmdWdata_r <= 32'h0000_0000;
      ifRdata_r  <= 32'h0000_0000;
      dRdata_r   <= 32'h0000_0000;
      misalign_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grantValid_s) begin
            owner_r    <= grantOwner_s;
            cmdAddr_r  <= cmdAddrNext_s;
            cmdWe_r    <= cmdWeNext_s;
            cmdBe_r    <= cmdBeNext_s;
            cmdWdata_r <= cmdWdataNext_s;
            misalign_r <= badStore_s;
          end
        end
        ST_ISSUE: cnt_r <= LAT_LOAD;
        ST_WAIT: begin
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r <= 3'd1 && !cmdWe_r) begin
            if (owner_r == OWN_IF) begin
              ifRdata_r <= memBus.mem_rdata;
            end else if (owner_r == OWN_D) begin
              dRdata_r <= memBus.mem_rdata;
            end
          end
        end
        ST_DONE: begin
          misalign_r <= 1'b0;
          if (owner_r != OWN_LD) begin
            lastCpu_r <= owner_r;
          end
        end
        default: cnt_r <= 3'd0;
      endcase
    end
  end

  assign memBus.mem_en    = (state_r == ST_ISSUE);
  assign memBus.mem_we    = (state_r == ST_ISSUE) && cmdWe_r;
  assign memBus.mem_be    = cmdBe_r;
  assign memBus.mem_addr  = cmdAddr_r;
  assign memBus.mem_wdata = cmdWdata_r;

  assign if_ready     = (state_r == ST_DONE) && (owner_r == OWN_IF);
  assign d_ready      = (state_r == ST_DONE) && (owner_r == OWN_D);
  assign ld_ready     = (state_r == ST_DONE) && (owner_r == OWN_LD);
  assign err_misalign = (state_r == ST_DONE) && misalign_r;
  assign if_rdata     = ifRdata_r;
  assign d_rdata      = dRdata_r;

  // Stall is combinational so the core freezes in the same cycle it issues a request
  assign cpu_stall = (if_req & ~if_ready) | (dPend_s & ~d_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: a MEM_LATENCY=1 instance covers fetch, tie, stores, load and misalignment;
// a MEM_LATENCY=3 instance covers loader priority, latency and reset during WAIT.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset1, reset3;
  logic        ifReq, ldReq;
  logic [31:0] ifAddr, dAddr, dWdata, ldAddr, ldWdata;
  logic [2:0]  dRd, dLen;
  logic [1:0]  dWr;

  logic [31:0] ifRdata1, dRdata1, ifRdata3, dRdata3;
  logic        ifReady1, dReady1, ldReady1, stall1, err1;
  logic        ifReady3, dReady3, ldReady3, stall3, err3;

  int numChecks = 0;
  int numErrors = 0;
  int waitCnt;
  logic anyReady;

  unified_mem_arbiter_if #(.ADDR_W(32)) bus1 ();
  unified_mem_arbiter_if #(.ADDR_W(32)) bus3 ();

  always #5 clk = ~clk;

  unified_mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
    .clock(clk), .reset(reset1),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata1), .if_ready(ifReady1),
    .d_rd(dRd), .d_wr(dWr), .d_addr(dAddr), .d_wdata(dWdata), .d_len(dLen),
    .d_rdata(dRdata1), .d_ready(dReady1),
    .ld_req(ldReq), .ld_addr(ldAddr), .ld_wdata(ldWdata), .ld_ready(ldReady1),
    .memBus(bus1), .cpu_stall(stall1), .err_misalign(err1)
  );

  unified_mem_arbiter #(.MEM_LATENCY(3), .ADDR_W(32)) dut3 (
    .clock(clk), .reset(reset3),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata3), .if_ready(ifReady3),
    .d_rd(dRd), .d_wr(dWr), .d_addr(dAddr), .d_wdata(dWdata), .d_len(dLen),
    .d_rdata(dRdata3), .d_ready(dReady3),
    .ld_req(ldReq), .ld_addr(ldAddr), .ld_wdata(ldWdata), .ld_ready(ldReady3),
    .memBus(bus3), .cpu_stall(stall3), .err_misalign(err3)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset1 = 1'b0; reset3 = 1'b0;
    ifReq = 1'b0; ifAddr = 32'h0; dRd = 3'b000; dWr = 2'b00; dAddr = 32'h0;
    dWdata = 32'h0; dLen = 3'b100; ldReq = 1'b0; ldAddr = 32'h0; ldWdata = 32'h0;
    bus1.mem_rdata = 32'h0; bus3.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    checkVal("rstIfReady", 32'(ifReady1), 32'h0);
    checkVal("rstDReady", 32'(dReady1), 32'h0);
    checkVal("rstLdReady", 32'(ldReady1), 32'h0);
    checkVal("rstMemEn", 32'(bus1.mem_en), 32'h0);
    checkVal("rstMemBe", 32'(bus1.mem_be), 32'h0);
    checkVal("rstMemAddr", bus1.mem_addr, 32'h0);
    checkVal("rstIfRdata", ifRdata1, 32'h0);
    checkVal("rstDRdata", dRdata1, 32'h0);
    checkVal("rstStall", 32'(stall1), 32'h0);
    checkVal("rstErr", 32'(err1), 32'h0);
    reset1 = 1'b1;
    tick();

    // Fetch only
    bus1.mem_rdata = 32'h2402000A;
    ifReq = 1'b1; ifAddr = 32'h40;
    #1;
    checkVal("fetchStallC0", 32'(stall1), 32'h1);
    tick();
    checkVal("fetchMemEnC1", 32'(bus1.mem_en), 32'h1);
    checkVal("fetchAddrC1", bus1.mem_addr, 32'h40);
    checkVal("fetchWeC1", 32'(bus1.mem_we), 32'h0);
    checkVal("fetchStallC1", 32'(stall1), 32'h1);
    tick();
    checkVal("fetchMemEnC2", 32'(bus1.mem_en), 32'h0);
    checkVal("fetchReadyC2", 32'(ifReady1), 32'h0);
    checkVal("fetchStallC2", 32'(stall1), 32'h1);
    tick();
    checkVal("fetchReadyC3", 32'(ifReady1), 32'h1);
    checkVal("fetchRdataC3", ifRdata1, 32'h2402000A);
    checkVal("fetchStallC3", 32'(stall1), 32'h0);
    ifReq = 1'b0;
    tick();
    checkVal("fetchReadyC4", 32'(ifReady1), 32'h0);

    // Tie after reset: IF first, then alternate
    reset1 = 1'b0;
    #2;
    reset1 = 1'b1;
    tick();
    ifReq = 1'b1; ifAddr = 32'h80;
    dWr = 2'b11; dLen = 3'b100; dAddr = 32'h100; dWdata = 32'h12345678;
    for (int n = 0; n < 6; n++) begin
      waitCnt = 0;
      while (!bus1.mem_en && waitCnt < 20) begin
        tick();
        waitCnt++;
      end
      checkVal($sformatf("tieIssue%0d", n), 32'(bus1.mem_en), 32'h1);
      checkVal($sformatf("tieAddr%0d", n), bus1.mem_addr, (n % 2 == 0) ? 32'h80 : 32'h100);
      checkVal($sformatf("tieWe%0d", n), 32'(bus1.mem_we), (n % 2 == 0) ? 32'h0 : 32'h1);
      waitCnt = 0;
      while (!(ifReady1 || dReady1) && waitCnt < 20) begin
        tick();
        waitCnt++;
      end
      checkVal($sformatf("tieGrant%0d", n), 32'({ifReady1, dReady1}),
               (n % 2 == 0) ? 32'h2 : 32'h1);
    end
    ifReq = 1'b0; dWr = 2'b00;
    tick();

    // Byte store to 0x103
    dWr = 2'b01; dLen = 3'b001; dAddr = 32'h103; dWdata = 32'h000000AB;
    tick();
    checkVal("byteMemEn", 32'(bus1.mem_en), 32'h1);
    checkVal("byteBe", 32'(bus1.mem_be), 32'h8);
    checkVal("byteWdata", bus1.mem_wdata, 32'hABABABAB);
    checkVal("byteAddr", bus1.mem_addr, 32'h100);
    checkVal("byteWe", 32'(bus1.mem_we), 32'h1);
    tick();
    tick();
    checkVal("byteReady", 32'(dReady1), 32'h1);
    dWr = 2'b00;
    tick();

    // Half store to 0x102
    dWr = 2'b01; dLen = 3'b010; dAddr = 32'h102; dWdata = 32'h00001234;
    tick();
    checkVal("halfBe", 32'(bus1.mem_be), 32'hC);
    checkVal("halfWdata", bus1.mem_wdata, 32'h12341234);
    checkVal("halfAddr", bus1.mem_addr, 32'h100);
    tick();
    tick();
    checkVal("halfReady", 32'(dReady1), 32'h1);
    dWr = 2'b00;
    tick();

    // Misaligned-address load returns the aligned word
    bus1.mem_rdata = 32'hCAFEF00D;
    dRd = 3'b010; dAddr = 32'h205;
    tick();
    checkVal("loadAddr", bus1.mem_addr, 32'h204);
    checkVal("loadWe", 32'(bus1.mem_we), 32'h0);
    checkVal("loadBe", 32'(bus1.mem_be), 32'hF);
    tick();
    tick();
    checkVal("loadReady", 32'(dReady1), 32'h1);
    checkVal("loadRdata", dRdata1, 32'hCAFEF00D);
    checkVal("loadStall", 32'(stall1), 32'h0);
    dRd = 3'b000;
    tick();

    // Misaligned word store to 0x102
    dWr = 2'b01; dLen = 3'b100; dAddr = 32'h102;
    #1;
    checkVal("misC0MemEn", 32'(bus1.mem_en), 32'h0);
    tick();
    checkVal("misC1MemEn", 32'(bus1.mem_en), 32'h0);
    checkVal("misC1Ready", 32'(dReady1), 32'h1);
    checkVal("misC1Err", 32'(err1), 32'h1);
    dWr = 2'b00;
    tick();
    checkVal("misC2Err", 32'(err1), 32'h0);
    checkVal("misC2MemEn", 32'(bus1.mem_en), 32'h0);

    // Loader priority with MEM_LATENCY=3
    reset3 = 1'b1;
    tick();
    bus3.mem_rdata = 32'h55AA55AA;
    ldReq = 1'b1; ldAddr = 32'h3F6; ldWdata = 32'hDEADBEEF;
    ifReq = 1'b1; ifAddr = 32'h44;
    dRd = 3'b001; dAddr = 32'h200;
    tick();
    checkVal("ldMemEn", 32'(bus3.mem_en), 32'h1);
    checkVal("ldAddr", bus3.mem_addr, 32'h3F4);
    checkVal("ldWe", 32'(bus3.mem_we), 32'h1);
    checkVal("ldBe", 32'(bus3.mem_be), 32'hF);
    checkVal("ldWdata", bus3.mem_wdata, 32'hDEADBEEF);
    tick();
    tick();
    tick();
    checkVal("ldReadyC4", 32'(ldReady3), 32'h0);
    tick();
    checkVal("ldReadyC5", 32'(ldReady3), 32'h1);
    ldReq = 1'b0;
    tick();
    tick();
    checkVal("postLdIssue", 32'(bus3.mem_en), 32'h1);
    checkVal("postLdAddr", bus3.mem_addr, 32'h44);
    tick();

    // Reset pulse during WAIT abandons the fetch
    reset3 = 1'b0;
    #1;
    checkVal("rstWaitIfReady", 32'(ifReady3), 32'h0);
    checkVal("rstWaitDReady", 32'(dReady3), 32'h0);
    checkVal("rstWaitLdReady", 32'(ldReady3), 32'h0);
    checkVal("rstWaitMemEn", 32'(bus3.mem_en), 32'h0);
    ifReq = 1'b0; dRd = 3'b000;
    #1;
    reset3 = 1'b1;
    anyReady = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      anyReady = anyReady | ifReady3 | dReady3 | ldReady3 | bus3.mem_en;
    end
    checkVal("rstWaitNoReady", 32'(anyReady), 32'h0);
    checkVal("rstWaitRdata", ifRdata3, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port unified memory between the CPU's instruction-fetch port, its data load/store port and a program-loader port, so the single-cycle core can run from one RAM. It sits between the CPU (which it stalls via `cpu_stall`) and the memory macro. It handles three things:
- arbitration (fixed-priority loader, round-robin between fetch and data);
- fixed-latency memory sequencing;
- store byte-lane generation from the CPU's 3-bit store length code.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..7.
- `ADDR_W`, default 32: byte address width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request. Held with `if_addr` stable until `if_ready`.
- `if_addr` in ADDR_W: fetch byte address. Bits [1:0] are ignored.
- `if_rdata` out 32: fetched word. Registered; valid while `if_ready` is high.
- `if_ready` out 1: one-cycle completion pulse for a fetch.
- `d_rd` in 3: load code. Nonzero means load.
- `d_wr` in 2: store code. Nonzero means store; takes precedence over `d_rd`.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in 32: store data, right-aligned.
- `d_len` in 3: store length. `001` = byte, `010` = half, `100` = word; other codes are treated as word.
- `d_rdata` out 32: raw loaded word (extension is done downstream). Registered.
- `d_ready` out 1: one-cycle completion pulse for a data access.
- `ld_req` in 1: loader word-write request.
- `ld_addr` in ADDR_W: loader address.
- `ld_wdata` in 32: loader write data.
- `ld_ready` out 1: one-cycle completion pulse for a loader write.
- `mem_en` out 1: memory access strobe; high for exactly one cycle per access.
- `mem_we` out 1: write enable, qualified by `mem_en`.
- `mem_be` out 4: byte enables. `1111` for reads.
- `mem_addr` out ADDR_W: word-aligned address (bits [1:0] = 0).
- `mem_wdata` out 32: lane-aligned write data.
- `mem_rdata` in 32: read data, valid `MEM_LATENCY` cycles after the `mem_en` cycle.
- `cpu_stall` out 1: `(if_req & ~if_ready) | ((d_rd!=0 | d_wr!=0) & ~d_ready)`.
- `err_misalign` out 1: one-cycle pulse on a misaligned store.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Registers: `owner` (LD/IF/D), `last_cpu` (IF/D) and a 3-bit latency counter.
- **IDLE:** arbitrate among pending requests.
  - Loader always wins.
  - Otherwise, when both fetch and data are pending, grant the one that is not `last_cpu`.
  - Latch the owner and the lane-aligned command; go to ISSUE.
  - If nothing is pending, stay in IDLE.
- **ISSUE:** assert `mem_en` with `mem_addr`, `mem_we`, `mem_be` and `mem_wdata`. Load the counter with `MEM_LATENCY`; go to WAIT.
- **WAIT:** decrement the counter. At count 1, register `mem_rdata` into the owner's rdata register (reads only) and go to DONE.
- **DONE:** pulse the owner's ready signal. Update `last_cpu` if the owner is IF or D. Return to IDLE. No arbitration happens in DONE, so a requester that holds `req` through its ready cycle is not regranted.
- **Store lanes:**
  - Byte: `be = 0001 << addr[1:0]`, byte replicated ×4.
  - Half: `addr[1]` selects `0011` or `1100`, halfword replicated ×2.
  - Word: `be = 1111`.
  - Loader writes are always full words, with `ld_addr[1:0]` ignored.
- **Misaligned store** (half with `addr[0]=1`, or word with `addr[1:0]≠0`):
  - IDLE goes directly to DONE.
  - `mem_en` is never asserted.
  - `d_ready` and `err_misalign` pulse together.
- **Misaligned load:** no check; the aligned word is returned.
- **Reset:** any outstanding access is abandoned and late `mem_rdata` is ignored. After reset the FSM is in IDLE and `last_cpu` = D, so fetch wins the first tie.

## Timing
- Reset values: all outputs are 0, including `if_rdata`, `d_rdata` and `mem_be`; `cpu_stall` follows its inputs combinationally.
- Request sampled high in IDLE at cycle 0:
  - ISSUE in cycle 1;
  - WAIT in cycles 2..1+`MEM_LATENCY`;
  - ready in cycle 2+`MEM_LATENCY`.
  - With `MEM_LATENCY`=1, an access takes 4 cycles.
- Back-to-back accesses: a new grant can be made in the cycle after DONE. Throughput is one access per 3+`MEM_LATENCY` cycles.
- All outputs except `cpu_stall` are registered or decoded from registered state.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum;
  - owner encoding (LD/IF/D);
  - length constants `LEN_B`/`LEN_H`/`LEN_W` = 3'b001/3'b010/3'b100.
- Sub-module `mem_lane_align`: purely combinational. Maps (`addr[1:0]`, `len`, `wdata`) to (`be`, aligned `wdata`, `misalign`).

## Test plan
- **Fetch only:** `if_req`=1, `if_addr`=0x40, memory returns 0x2402000A → `mem_en` high in cycle 1 with `mem_addr`=0x40; `if_ready` pulses in cycle 3 with `if_rdata`=0x2402000A; `cpu_stall` is high for cycles 0–2.
- **Tie:** `if_req` and store-word (`d_addr`=0x100) asserted together after reset → fetch is granted first, then data. After that, with both still requesting, grants alternate IF, D, IF, D.
- **Byte store:** `d_addr`=0x103, `d_wdata`=0x000000AB, `d_len`=001 → `mem_be`=1000, `mem_wdata`=0xABABABAB, `mem_addr`=0x100.
- **Misaligned store:** word store to 0x102 → no `mem_en`; `d_ready` and `err_misalign` pulse in cycle 1.
- **Loader priority and latency:** `MEM_LATENCY`=3 with `ld_req`, `if_req` and `d_req` all pending → loader is granted first and `ld_ready` pulses at cycle 5. A `reset` pulse in a WAIT cycle returns the FSM to IDLE with all ready signals 0, and no ready pulse follows.
